uart_tx: RTL and testbench

UART transmitter that serialises one byte per request as 8N1 (start, 8 data bits LSB first, stop), with an optional even-parity bit. It is the transmit counterpart of `uart_rx` and shares its divisor convention: one oversample tick every `div_i`+1 clocks and 16 ticks per bit. It sits between the host-side byte source and the board TX pin.

---
 rtl/uart_pkg.sv | 8 +
 rtl/uart_baud_gen.sv | 24 ++
 rtl/uart_tx.sv | 146 ++++++++++++++
 tb/tb_uart_tx.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry, divisor width and FSM state encoding.
package uart_pkg;
  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;
  localparam int DIV_W      = 11;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;
endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator: one tick every div_i+1 clocks, restartable via clr_i.
module uart_baud_gen
  import uart_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);
  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == div_i);

  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clr_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter, 16 oversample ticks per bit.
// Define UART_TX_PARITY_EN to insert an even-parity bit before the stop bit.
module uart_tx
  import uart_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [DIV_W-1:0]     div_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 tx_start_i,
  output logic                 tx_o,
  output logic                 tx_busy_o,
  output logic                 tx_done_o
);
  localparam int TCNT_W = $clog2(OVERSAMPLE);

  uart_state_t          state_q, state_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic [TCNT_W-1:0]    tcnt_q, tcnt_d;
  logic [2:0]           bcnt_q, bcnt_d;
  logic                 tx_q, tx_d, busy_q, busy_d, done_q, done_d;
  logic                 clr, tick, bit_end;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  uart_baud_gen u_baud (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (clr),
    .div_i  (div_q),
    .tick_o (tick)
  );

  // A bit ends on the last of its 16 ticks; tx_d then carries the next bit's level.
  assign bit_end = tick && (tcnt_q == TCNT_W'(OVERSAMPLE - 1));

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    div_d   = div_q;
    tcnt_d  = tcnt_q;
    bcnt_d  = bcnt_q;
    tx_d    = tx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    clr     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != IDLE && tick) tcnt_d = tcnt_q + TCNT_W'(1);

    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
        if (tx_start_i) begin
          shift_d = data_i;
          div_d   = div_i;
          tcnt_d  = '0;
          bcnt_d  = '0;
          clr     = 1'b1;
          state_d = START;
          tx_d    = 1'b0;
          busy_d  = 1'b1;
`ifdef UART_TX_PARITY_EN
          par_d   = ^data_i;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          tx_d    = shift_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            tx_d = shift_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          tx_d    = 1'b1;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      shift_q <= '0;
      div_q   <= '0;
      tcnt_q  <= '0;
      bcnt_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      div_q   <= div_d;
      tcnt_q  <= tcnt_d;
      bcnt_q  <= bcnt_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_o      = tx_q;
  assign tx_busy_o = busy_q;
  assign tx_done_o = done_q;
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: frame-level reference model plus directed and random stimulus.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int FB         = 11;
  localparam int FRAME_CLKS = 4048;
`else
  localparam int FB         = 10;
  localparam int FRAME_CLKS = 3680;
`endif
  localparam int BIT_CLKS = 368;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] div_i;
  logic [7:0]  data_i;
  logic        tx_start;
  logic        tx_o, tx_busy, tx_done;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  uart_tx dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .div_i      (div_i),
    .data_i     (data_i),
    .tx_start_i (tx_start),
    .tx_o       (tx_o),
    .tx_busy_o  (tx_busy),
    .tx_done_o  (tx_done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference model: a frame is a list of FB line levels, each held for 16*(div+1) clocks.
  logic m_bits[11];
  int   m_b = 16;
  int   m_pos = 0;
  bit   m_active = 1'b0;
  bit   m_done = 1'b0;
  bit   m_live = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_done   = 1'b0;
      m_pos    = 0;
    end else if (m_active) begin
      m_pos++;
      if (m_pos == FB * m_b) begin
        m_active = 1'b0;
        m_done   = 1'b1;
      end
    end else begin
      m_done = 1'b0;
      if (tx_start) begin
        m_active  = 1'b1;
        m_pos     = 0;
        m_b       = 16 * (int'(div_i) + 1);
        m_bits[0] = 1'b0;
        for (int k = 0; k < 8; k++) m_bits[k+1] = data_i[k];
        m_bits[9]    = ^data_i;
        m_bits[FB-1] = 1'b1;
      end
    end
    m_live = 1'b1;
  end

  always @(negedge clk) begin
    if (m_live) begin
      logic exp_tx;
      exp_tx = m_active ? m_bits[m_pos / m_b] : 1'b1;
      check("outputs{tx,busy,done}", 32'({tx_o, tx_busy, tx_done}),
            32'({exp_tx, m_active, m_done}));
    end
  end

  task automatic start_frame(input logic [7:0] d);
    data_i   = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Waits for the start bit, samples each bit at its midpoint, then waits for tx_done.
  task automatic capture(input int b, output logic [10:0] bits, output int t0, output int done_lat);
    int guard;
    bits  = '0;
    guard = 0;
    while (tx_o !== 1'b0 && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    check("start_bit_seen", 32'(tx_o), 32'(0));
    t0 = cyc;
    for (int k = 0; k < FB; k++) begin
      while (cyc < t0 + k * b + b / 2) @(negedge clk);
      bits[k] = tx_o;
    end
    guard = 0;
    while (tx_done !== 1'b1 && guard < FB * b + 20) begin
      @(negedge clk);
      guard++;
    end
    check("done_seen", 32'(tx_done), 32'(1));
    done_lat = cyc - t0;
  endtask

  initial begin
    logic [10:0] b1, b2;
    int t0a, t0b, dla, dlb;

    rst_n    = 1'b0;
    tx_start = 1'b0;
    data_i   = 8'h00;
    div_i    = 11'h16;
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_tx", 32'(tx_o), 32'(1));
    check("reset_busy", 32'(tx_busy), 32'(0));
    check("reset_done", 32'(tx_done), 32'(0));

    // 0x15: mid-bit samples 0,1,0,1,0,1,0,0,0,1
    start_frame(8'h15);
    check("first_low_tx", 32'(tx_o), 32'(0));
    check("first_low_busy", 32'(tx_busy), 32'(1));
    capture(BIT_CLKS, b1, t0a, dla);
    check("bits_0x15", 32'(b1[9:0]), 32'(10'b1000101010));
    check("done_latency_0x15", 32'(dla), 32'(FRAME_CLKS));

    // start held high: 0x12 then 0x34 back to back
    data_i   = 8'h12;
    tx_start = 1'b1;
    @(negedge clk);
    data_i = 8'h34;
    capture(BIT_CLKS, b1, t0a, dla);
    @(negedge clk);
    tx_start = 1'b0;
    capture(BIT_CLKS, b2, t0b, dlb);
    check("b2b_byte0", 32'(b1[8:1]), 32'(8'h12));
    check("b2b_byte1", 32'(b2[8:1]), 32'(8'h34));
    check("b2b_spacing", 32'(t0b - t0a), 32'(FRAME_CLKS + 1));

    // start pulse with new data/divisor mid-frame is ignored
    start_frame(8'h12);
    fork
      capture(BIT_CLKS, b1, t0a, dla);
      begin
        repeat (1000) @(negedge clk);
        data_i   = 8'h99;
        div_i    = 11'h003;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
      end
    join
    div_i = 11'h16;
    check("ignore_start_byte", 32'(b1[8:1]), 32'(8'h12));
    check("ignore_start_len", 32'(dla), 32'(FRAME_CLKS));
    repeat (500) @(negedge clk);
    check("no_extra_frame", 32'(tx_busy), 32'(0));

    // reset in the middle of the data bits of 0xA5
    start_frame(8'hA5);
    repeat (3 * BIT_CLKS) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_tx", 32'(tx_o), 32'(1));
    check("abort_busy", 32'(tx_busy), 32'(0));
    check("abort_done", 32'(tx_done), 32'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_no_done", 32'(tx_done), 32'(0));
    start_frame(8'h3C);
    capture(BIT_CLKS, b1, t0a, dla);
    check("after_abort_byte", 32'(b1[8:1]), 32'(8'h3C));
    check("after_abort_stop", 32'(b1[FB-1]), 32'(1));

`ifdef UART_TX_PARITY_EN
    start_frame(8'h07);
    capture(BIT_CLKS, b1, t0a, dla);
    check("parity_0x07", 32'(b1[9]), 32'(1));
    check("parity_frame_len", 32'(dla), 32'(4048));
`endif

    // random traffic: small divisors, random requests, data/div churn and rare resets
    for (int i = 0; i < 20000; i++) begin
      tx_start = ($urandom_range(0, 7) == 0);
      data_i   = 8'($urandom);
      div_i    = 11'($urandom_range(0, 3));
      rst_n    = ($urandom_range(0, 4999) != 0);
      @(negedge clk);
    end
    rst_n    = 1'b1;
    tx_start = 1'b0;
    repeat (10) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
